cp0_unit: RTL and testbench

- Coprocessor 0 for the 5-stage MIPS pipeline; sits beside the M stage.
- Holds the SR, Cause, EPC and PRId registers, serves mfc0/mtc0, and arbitrates hardware interrupts against exceptions carried down the pipe.
- Produces int_req, the request that flushes the pipeline registers and redirects fetch to the handler at 0x0000_4180.
- Produces epc, the eret return target.

---
 rtl/cp0_unit_pkg.sv | 23 ++
 rtl/cp0_unit_timer.sv | 37 +++
 rtl/cp0_unit.sv | 123 ++++++++++++
 tb/tb_cp0_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values and the handler entry address.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_unit_timer.sv
// Count/Compare timer for CP0; the pending flag is raised on Count == Compare and cleared by a Compare write.
module cp0_timer
  import cp0_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  // Blocks the spurious 0 == 0 match in the first cycle out of reset.
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (we && a2 == CP0_COUNT) count <= din;
      else                       count <= count + 32'd1;
      if (we && a2 == CP0_COMPARE) begin
        compare <= din;
        pending <= 1'b0;
      end else if (armed && count == compare) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/PRId, mfc0/mtc0, interrupt vs exception arbitration.
// Optional Count/Compare timer (regs 9/11, ORed into hw_int[5]) is enabled by defining CP0_COUNT_EN.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2021_0707,
  parameter logic [31:0] HANDLER_PC = HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        int_req,
  output logic [31:0] epc,
  output logic [31:0] dout,
  output logic [31:0] handler_pc
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_r;
  logic [5:0]  hw_eff;
  logic        irq;
  logic        exc;
  logic [31:0] pc_al;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        unused_pc_bits;

`ifdef CP0_COUNT_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;

  // An mtc0 squashed by int_req must not reach the timer either.
  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (we & ~int_req),
    .a2      (a2),
    .din     (din),
    .count   (count),
    .compare (compare),
    .pending (pending)
  );

  assign hw_eff = {hw_int[5] | pending, hw_int[4:0]};
`else
  assign hw_eff = hw_int;
`endif

  assign irq      = (|(hw_eff & im)) & ie & ~exl;
  assign exc      = (m_exc != EXC_INT) & ~exl;
  assign int_req  = irq | exc;

  assign pc_al    = word_align(m_pc);
  assign epc_next = m_bd ? pc_al - 32'd4 : pc_al;
  assign unused_pc_bits = ^m_pc[1:0];

  assign epc        = epc_r;
  assign handler_pc = HANDLER_PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= EXC_INT;
      epc_r    <= '0;
    end else begin
      ip <= hw_eff;
      if (int_req) begin
        exl      <= 1'b1;
        bd       <= m_bd;
        exc_code <= irq ? EXC_INT : m_exc;
        epc_r    <= epc_next;
      end else begin
        // mtc0 to SR lands first; a concurrent eret then clears EXL.
        if (we && a2 == CP0_SR) begin
          im  <= din[15:10];
          ie  <= din[0];
          exl <= din[1] & ~exl_clr;
        end else if (exl_clr) begin
          exl <= 1'b0;
        end
        if (we && a2 == CP0_EPC) epc_r <= word_align(din);
      end
    end
  end

  assign sr_val    = {16'h0, im, 8'h0, exl, ie};
  assign cause_val = {bd, 15'h0, ip, 3'b000, exc_code, 2'b00};

  always_comb begin
    dout = '0;
    case (a1)
      CP0_SR:      dout = sr_val;
      CP0_CAUSE:   dout = cause_val;
      CP0_EPC:     dout = epc_r;
      CP0_PRID:    dout = PRID_VAL;
`ifdef CP0_COUNT_EN
      CP0_COUNT:   dout = count;
      CP0_COMPARE: dout = compare;
`endif
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Table-driven bench for cp0_unit: per-row int_req/dout checks plus an EPC scoreboard checked after each edge.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2021_0707;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] dout;
  logic [31:0] handler_pc;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .a1         (a1),
    .a2         (a2),
    .din        (din),
    .we         (we),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exc      (m_exc),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .int_req    (int_req),
    .epc        (epc),
    .dout       (dout),
    .handler_pc (handler_pc)
  );

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        ireq;
    logic [31:0] dout;
    logic [31:0] epc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] epc_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] ra1, input logic [4:0] ra2, input logic [31:0] rdin,
                     input logic rwe, input logic [31:0] rpc, input logic rbd, input logic [4:0] rexc,
                     input logic [5:0] rhw, input logic rclr, input logic rireq,
                     input logic [31:0] rdout, input logic [31:0] repc);
    vec_t v;
    v.a1 = ra1; v.a2 = ra2; v.din = rdin; v.we = rwe; v.pc = rpc; v.bd = rbd;
    v.exc = rexc; v.hw = rhw; v.clr = rclr; v.ireq = rireq; v.dout = rdout; v.epc = repc;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    a1 = 5'd0; a2 = 5'd0; din = '0; we = 1'b0; m_pc = 32'h1000;
    m_bd = 1'b0; m_exc = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] exp_epc;
    @(negedge clk);
    a1 = v.a1; a2 = v.a2; din = v.din; we = v.we; m_pc = v.pc; m_bd = v.bd;
    m_exc = v.exc; hw_int = v.hw; exl_clr = v.clr;
    #1;
    check($sformatf("row%0d int_req", idx), {31'h0, int_req}, {31'h0, v.ireq});
    check($sformatf("row%0d dout", idx), dout, v.dout);
    epc_q.push_back(v.epc);
    @(posedge clk);
    #1;
    exp_epc = epc_q.pop_front();
    check($sformatf("row%0d epc", idx), epc, exp_epc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    //   a1  a2  din           we  pc            bd  exc    hw         clr  ireq dout          epc_after
    add(12,  0, 32'h0,        0, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, 32'h0,        32'h0);
    add(13,  0, 32'h0,        0, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, 32'h0,        32'h0);
    add(14,  0, 32'h0,        0, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, 32'h0,        32'h0);
    add(15,  0, 32'h0,        0, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, PRID,         32'h0);
    add( 1,  1, 32'hFFFF_FFFF,1, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, 32'h0,        32'h0);
    add(12, 12, 32'h0000_FC01,1, 32'h1000,     0, 5'd0,  6'b000000, 0,   0, 32'h0,        32'h0);
    add(12,  0, 32'h0,        0, 32'h2000,     0, 5'd0,  6'b000100, 0,   1, 32'h0000_FC01, 32'h2000);
    add(13,  0, 32'h0,        0, 32'h2004,     0, 5'd0,  6'b000100, 0,   0, 32'h0000_1000, 32'h2000);
    add(12,  0, 32'h0,        0, 32'h2008,     0, 5'd0,  6'b000000, 0,   0, 32'h0000_FC03, 32'h2000);
    add(14, 14, 32'h0000_1237,1, 32'h200C,     0, 5'd0,  6'b000000, 1,   0, 32'h0000_2000, 32'h1234);
    add(14,  0, 32'h0,        0, 32'h2010,     0, 5'd0,  6'b000000, 0,   0, 32'h0000_1234, 32'h1234);
    add(12, 12, 32'h0,        1, 32'h2014,     0, 5'd0,  6'b000000, 0,   0, 32'h0000_FC01, 32'h1234);
    add(12,  0, 32'h0,        0, 32'h3004,     1, 5'd12, 6'b000000, 0,   1, 32'h0,        32'h3000);
    add(13,  0, 32'h0,        0, 32'h3008,     0, 5'd12, 6'b000000, 0,   0, 32'h8000_0030, 32'h3000);
    add(12, 12, 32'h0000_FC01,1, 32'h300C,     0, 5'd0,  6'b000000, 1,   0, 32'h0000_0002, 32'h3000);
    add(13, 14, 32'h0000_5000,1, 32'h4008,     0, 5'd4,  6'b000001, 0,   1, 32'h8000_0030, 32'h4008);
    add(13,  0, 32'h0,        0, 32'h400C,     0, 5'd0,  6'b000000, 0,   0, 32'h0000_0400, 32'h4008);
    add(12,  0, 32'h0,        0, 32'h4010,     0, 5'd10, 6'b000010, 0,   0, 32'h0000_FC03, 32'h4008);
    add(13,  0, 32'h0,        0, 32'h4014,     0, 5'd0,  6'b000010, 1,   0, 32'h0000_0800, 32'h4008);
    add(12,  0, 32'h0,        0, 32'h5000,     0, 5'd0,  6'b000010, 0,   1, 32'h0000_FC01, 32'h5000);
    add(12,  0, 32'h0,        0, 32'h5004,     0, 5'd0,  6'b000000, 1,   0, 32'h0000_FC03, 32'h5000);
    add(14,  0, 32'h0,        0, 32'h6000,     0, 5'd5,  6'b000000, 1,   1, 32'h0000_5000, 32'h6000);
    add(12,  0, 32'h0,        0, 32'h6004,     0, 5'd0,  6'b000000, 0,   0, 32'h0000_FC03, 32'h6000);

    do_reset();
    check("handler_pc", handler_pc, 32'h0000_4180);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset in the middle of a handler (EXL=1, IM/IE set) with an interrupt line held.
    @(negedge clk);
    idle_inputs();
    hw_int = 6'b000001;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    a1 = 5'd12;
    #1;
    check("rst_mid sr", dout, 32'h0);
    check("rst_mid int_req", {31'h0, int_req}, 32'h0);
    check("rst_mid epc", epc, 32'h0);
    a1 = 5'd13;
    #1;
    check("rst_mid cause", dout, 32'h0);
    a1 = 5'd15;
    #1;
    check("rst_mid prid", dout, PRID);

`ifdef CP0_COUNT_EN
    begin
      int n;
      do_reset();
      we = 1'b1; a2 = 5'd12; din = 32'h0000_8001;
      @(negedge clk);
      a2 = 5'd11; din = 32'd20;
      @(negedge clk);
      a2 = 5'd9; din = 32'd0;
      @(negedge clk);
      we = 1'b0; a1 = 5'd13;
      n = 0;
      while (!int_req && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("timer int_req", {31'h0, int_req}, 32'h1);
      checks++;
      if (n < 19 || n > 23) begin
        errors++;
        $display("FAIL timer latency: got %0d cycles, expected 19..23", n);
      end
      @(negedge clk);
      we = 1'b1; a2 = 5'd11; din = 32'd1000;
      @(negedge clk);
      we = 1'b0;
      @(negedge clk);
      check("timer ip cleared", {31'h0, dout[15]}, 32'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
